// File: rtl/wvb_reader_arb.sv
// Rotating-priority, skip-empty WVB reader arbiter feeding a read controller and DPRAM handshake; data path latency 2 clk.
// Optional block/timeout statistics counters are built only when WVB_READER_ARB_STATS_EN is defined.
module wvb_reader_arb #(
  parameter int N_CHANNELS    = 2,
  parameter int P_DATA_WIDTH  = 22,
  parameter int P_HDR_WIDTH   = 80,
  parameter int P_HDR_WT_CNT  = 3,
  parameter int P_TIMEOUT_CNT = 1024,
  parameter int CH_W          = 5
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_en,
  input  logic [N_CHANNELS-1:0]             i_chan_mask,
  input  logic [N_CHANNELS-1:0]             i_hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0] i_hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] i_wvb_data,
  output logic [N_CHANNELS-1:0]             o_hdr_rdreq,
  output logic [N_CHANNELS-1:0]             o_wvb_rdreq,
  output logic [N_CHANNELS-1:0]             o_wvb_rddone,
  output logic                              o_rc_req,
  input  logic                              i_rc_ack,
  input  logic                              i_rc_more,
  input  logic [15:0]                       i_rc_len,
  output logic                              o_rc_abort,
  input  logic                              i_rc_wvb_rdreq,
  input  logic                              i_rc_wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]            o_rc_hdr_data,
  output logic [P_DATA_WIDTH-1:0]           o_rc_wvb_data,
  output logic [7:0]                        o_rc_idx,
  input  logic                              i_dpram_busy,
  input  logic                              i_dpram_mode,
  output logic                              o_dpram_run,
  output logic [15:0]                       o_dpram_len,
  output logic                              o_timeout_err,
  input  logic                              i_err_clr,
  output logic [31:0]                       o_stat_xfers,
  output logic [15:0]                       o_stat_timeouts
);

  localparam int TMR_W = $clog2(P_TIMEOUT_CNT) + 1;
  localparam int HWC_W = $clog2(P_HDR_WT_CNT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(P_TIMEOUT_CNT - 1);
  localparam logic [HWC_W-1:0] HWC_LAST = HWC_W'(P_HDR_WT_CNT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_WAIT, S_RC_REQ, S_DPRAM_RUN, S_DPRAM_BUSY, S_DPRAM_DONE, S_MORE_WAIT
  } state_t;

  state_t                            r_state;
  logic [CH_W-1:0]                   r_chan_index;
  logic [CH_W-1:0]                   r_last_served;
  logic [HWC_W-1:0]                  r_cnt;
  logic [TMR_W-1:0]                  r_tmr;
  logic                              r_hdr_stb;
  logic                              r_rc_req;
  logic                              r_rc_abort;
  logic                              r_dpram_run;
  logic [15:0]                       r_dpram_len;
  logic                              r_timeout_err;
  logic [N_CHANNELS*P_HDR_WIDTH-1:0] r_hdr_in;
  logic [N_CHANNELS*P_DATA_WIDTH-1:0] r_wvb_in;
  logic [P_HDR_WIDTH-1:0]            r_rc_hdr;
  logic [P_DATA_WIDTH-1:0]           r_rc_wvb;

  logic [N_CHANNELS-1:0] w_elig;
  logic [CH_W-1:0]       w_grant;
  logic                  w_grant_ok;
  logic                  w_timeout;
  logic                  w_xfer_done;
  logic                  w_active;

  assign w_elig      = ~i_hdr_empty & i_chan_mask;
  assign w_grant_ok  = (|w_elig) && !i_dpram_busy && !i_rc_ack;
  assign w_timeout   = i_en && (r_state == S_DPRAM_BUSY) && !i_dpram_busy && (r_tmr == TMR_LAST);
  assign w_xfer_done = i_en && (r_state == S_DPRAM_DONE) && !i_dpram_busy;
  assign w_active    = (r_state != S_IDLE);

  // Scan downward so the closest eligible channel after last_served is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    for (int k = N_CHANNELS; k >= 1; k--) begin
      idx = (int'(r_last_served) + k) % N_CHANNELS;
      if (w_elig[idx]) w_grant = CH_W'(idx);
    end
  end

  always_comb begin
    o_hdr_rdreq  = '0;
    o_wvb_rdreq  = '0;
    o_wvb_rddone = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (r_chan_index == CH_W'(i)) begin
        o_hdr_rdreq[i]  = r_hdr_stb;
        o_wvb_rdreq[i]  = i_rc_wvb_rdreq && w_active;
        o_wvb_rddone[i] = i_rc_wvb_rddone && w_active;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_chan_index  <= '0;
      r_last_served <= CH_LAST;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_hdr_stb     <= 1'b0;
      r_rc_req      <= 1'b0;
      r_rc_abort    <= 1'b0;
      r_dpram_run   <= 1'b0;
      r_dpram_len   <= '0;
      r_timeout_err <= 1'b0;
      r_hdr_in      <= '0;
      r_wvb_in      <= '0;
      r_rc_hdr      <= '0;
      r_rc_wvb      <= '0;
    end else if (!i_en) begin
      // Abort any transfer in flight; timeout_err is deliberately left alone.
      r_rc_abort    <= w_active;
      r_state       <= S_IDLE;
      r_chan_index  <= '0;
      r_last_served <= CH_LAST;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_hdr_stb     <= 1'b0;
      r_rc_req      <= 1'b0;
      r_dpram_run   <= 1'b0;
      r_dpram_len   <= '0;
      r_hdr_in      <= '0;
      r_wvb_in      <= '0;
      r_rc_hdr      <= '0;
      r_rc_wvb      <= '0;
      if (i_err_clr) r_timeout_err <= 1'b0;
    end else begin
      r_hdr_stb   <= 1'b0;
      r_dpram_run <= 1'b0;
      r_rc_abort  <= 1'b0;
      r_hdr_in    <= i_hdr_data;
      r_wvb_in    <= i_wvb_data;
      r_rc_hdr    <= r_hdr_in[r_chan_index*P_HDR_WIDTH +: P_HDR_WIDTH];
      r_rc_wvb    <= r_wvb_in[r_chan_index*P_DATA_WIDTH +: P_DATA_WIDTH];
      if (i_err_clr) r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant_ok) begin
          r_chan_index <= w_grant;
          r_hdr_stb    <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_HDR_WAIT;
        end
        S_HDR_WAIT: if (r_cnt == HWC_LAST) begin
          r_rc_req <= 1'b1;
          r_state  <= S_RC_REQ;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_RC_REQ: if (i_rc_ack) begin
          r_rc_req    <= 1'b0;
          r_dpram_len <= i_rc_len;
          r_state     <= S_DPRAM_RUN;
        end
        S_DPRAM_RUN: if (!i_dpram_busy) begin
          r_dpram_run <= 1'b1;
          r_tmr       <= '0;
          r_state     <= S_DPRAM_BUSY;
        end
        S_DPRAM_BUSY: if (i_dpram_busy) begin
          r_state <= S_DPRAM_DONE;
        end else if (w_timeout) begin
          r_timeout_err <= 1'b1;
          r_rc_abort    <= 1'b1;
          r_last_served <= r_chan_index;
          r_state       <= S_IDLE;
        end else begin
          r_tmr <= r_tmr + 1'b1;
        end
        S_DPRAM_DONE: if (w_xfer_done) begin
          if (i_dpram_mode && i_rc_more) begin
            r_state <= S_MORE_WAIT;
          end else begin
            r_last_served <= r_chan_index;
            r_state       <= S_IDLE;
          end
        end
        S_MORE_WAIT: if (!i_rc_ack) begin
          r_rc_req <= 1'b1;
          r_state  <= S_RC_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rc_req      = r_rc_req;
  assign o_rc_abort    = r_rc_abort;
  assign o_dpram_run   = r_dpram_run;
  assign o_dpram_len   = r_dpram_len;
  assign o_timeout_err = r_timeout_err;
  assign o_rc_hdr_data = r_rc_hdr;
  assign o_rc_wvb_data = r_rc_wvb;
  assign o_rc_idx      = 8'(r_chan_index);

`ifdef WVB_READER_ARB_STATS_EN
  logic [31:0] r_stat_xfers;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_xfers    <= '0;
      r_stat_timeouts <= '0;
    end else if (!i_en) begin
      r_stat_xfers    <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_xfer_done) r_stat_xfers <= r_stat_xfers + 1'b1;
      if (w_timeout && (r_stat_timeouts != 16'hFFFF)) r_stat_timeouts <= r_stat_timeouts + 1'b1;
    end
  end

  assign o_stat_xfers    = r_stat_xfers;
  assign o_stat_timeouts = r_stat_timeouts;
`else
  assign o_stat_xfers    = '0;
  assign o_stat_timeouts = '0;
`endif

endmodule
